// File: rtl/load_store_unit.sv
// Load/store unit between the core and a word-only data memory. Byte/halfword stores
// run a two-cycle read-modify-write; misaligned, out-of-range and illegal requests are
// blocked, flagged and counted in a saturating counter.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_EN,
    input  logic             ST_EN,
    input  logic [2:0]       FUNCT3,
    input  logic [31:0]      ADDR,
    input  logic [31:0]      WDATA,
    output logic [31:0]      LOAD_DATA,
    output logic             STALL,
    output logic             FAULT,
    output logic [CNT_W-1:0] FAULT_CNT,
    output logic             MEMR,
    output logic             MEMW,
    output logic [31:0]      MEM_ADDRESS,
    output logic [31:0]      MEM_DATA_W,
    input  logic [31:0]      MEM_DATA_R
);

    localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    state_e           state_q, state_d;
    logic [31:0]      merge_q, merge_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [29:0] word_idx;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign word_idx = ADDR[31:2];

    // Request legality: funct3 decode, alignment and range; only meaningful in StIdle.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (FUNCT3)
            3'b000:  illegal = 1'b0;
            3'b001:  misaligned = ADDR[0];
            3'b010:  misaligned = (ADDR[1:0] != 2'b00);
            3'b100:  illegal = ST_EN;
            3'b101: begin
                illegal    = ST_EN;
                misaligned = ADDR[0];
            end
            default: illegal = 1'b1;
        endcase
        out_of_range = ({2'b00, word_idx} >= 32'(MEM_WORDS));
        fault        = (state_q == StIdle) & (LD_EN | ST_EN) &
                       ((LD_EN & ST_EN) | illegal | misaligned | out_of_range);
    end

    // Lane extraction and sign/zero extension of the read word for loads.
    always_comb begin
        case (ADDR[1:0])
            2'd0:    byte_lane = MEM_DATA_R[7:0];
            2'd1:    byte_lane = MEM_DATA_R[15:8];
            2'd2:    byte_lane = MEM_DATA_R[23:16];
            default: byte_lane = MEM_DATA_R[31:24];
        endcase
        half_lane = ADDR[1] ? MEM_DATA_R[31:16] : MEM_DATA_R[15:0];
        case (FUNCT3)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b010:  load_ext = MEM_DATA_R;
            3'b100:  load_ext = {24'h0, byte_lane};
            3'b101:  load_ext = {16'h0, half_lane};
            default: load_ext = 32'h0;
        endcase
    end

    // Old word with the addressed byte (SB) or halfword (SH) replaced by store data.
    always_comb begin
        merged = MEM_DATA_R;
        if (!FUNCT3[0]) begin
            case (ADDR[1:0])
                2'd0:    merged[7:0]   = WDATA[7:0];
                2'd1:    merged[15:8]  = WDATA[7:0];
                2'd2:    merged[23:16] = WDATA[7:0];
                default: merged[31:24] = WDATA[7:0];
            endcase
        end else if (ADDR[1]) begin
            merged[31:16] = WDATA[15:0];
        end else begin
            merged[15:0] = WDATA[15:0];
        end
    end

    // Next-state and memory-side outputs; everything is quiet while RST is high.
    always_comb begin
        state_d     = state_q;
        merge_d     = merge_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        MEMR        = 1'b0;
        MEMW        = 1'b0;
        STALL       = 1'b0;
        FAULT       = 1'b0;
        LOAD_DATA   = 32'h0;
        MEM_ADDRESS = {2'b00, word_idx};
        MEM_DATA_W  = WDATA;
        if (!RST) begin
            unique case (state_q)
                StIdle: begin
                    if (fault) begin
                        FAULT = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (LD_EN) begin
                        MEMR      = 1'b1;
                        LOAD_DATA = load_ext;
                    end else if (ST_EN) begin
                        if (FUNCT3 == 3'b010) begin
                            MEMW = 1'b1;
                        end else begin
                            // First half of RMW: read the old word and stall the core.
                            MEMR    = 1'b1;
                            STALL   = 1'b1;
                            merge_d = merged;
                            idx_d   = word_idx[IdxW-1:0];
                            state_d = StRmwWr;
                        end
                    end
                end
                StRmwWr: begin
                    MEMW        = 1'b1;
                    MEM_DATA_W  = merge_q;
                    MEM_ADDRESS = 32'(idx_q);
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, merge word, latched index and fault counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            merge_q <= 32'h0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign FAULT_CNT = cnt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a simple word memory, a transaction-level reference model
// and a scoreboard queue checked by an independent monitor.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LD_EN, ST_EN;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR, WDATA;
    logic [31:0] LOAD_DATA;
    logic        STALL, FAULT;
    logic [7:0]  FAULT_CNT;
    logic        MEMR, MEMW;
    logic [31:0] MEM_ADDRESS, MEM_DATA_W, MEM_DATA_R;

    typedef struct {
        int          kind;  // 0 load, 1 write, 2 fault
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem[64];
    logic [31:0] mem[64];
    int          cnt_model = 0;
    int          total = 0;
    int          bad = 0;

    always #5 CLK = ~CLK;

    load_store_unit #(.MEM_WORDS(64), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .LD_EN(LD_EN), .ST_EN(ST_EN), .FUNCT3(FUNCT3),
        .ADDR(ADDR), .WDATA(WDATA), .LOAD_DATA(LOAD_DATA), .STALL(STALL),
        .FAULT(FAULT), .FAULT_CNT(FAULT_CNT), .MEMR(MEMR), .MEMW(MEMW),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA_W(MEM_DATA_W), .MEM_DATA_R(MEM_DATA_R)
    );

    // Data memory: cleared by the shared reset, writes at the clock edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (MEMW && MEM_ADDRESS < 32'd64) begin
            mem[MEM_ADDRESS[5:0]] <= MEM_DATA_W;
        end
    end
    assign MEM_DATA_R = (MEMR && MEM_ADDRESS < 32'd64) ? mem[MEM_ADDRESS[5:0]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented load result, write or fault pops one expected entry.
    always @(negedge CLK) begin : mon
        exp_t e;
        int   kind;
        if (!RST && (FAULT || MEMW || (MEMR && !STALL))) begin
            kind = FAULT ? 2 : (MEMW ? 1 : 0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output act=kind%0d exp=none", kind);
            end else begin
                e = sbq.pop_front();
                chk("kind", 32'(kind), 32'(e.kind));
                if (kind == e.kind) begin
                    case (kind)
                        0: begin
                            chk("load_addr", MEM_ADDRESS, e.addr);
                            chk("load_data", LOAD_DATA, e.data);
                        end
                        1: begin
                            chk("write_addr", MEM_ADDRESS, e.addr);
                            chk("write_data", MEM_DATA_W, e.data);
                        end
                        default: chk("fault_quiet", {30'h0, MEMR, MEMW} | LOAD_DATA, 32'h0);
                    endcase
                end
            end
        end
    end

    // Issue one request; the model decides the expected outcome from the ISA rules.
    task automatic op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit dchk = 1'b0,
                      input logic [31:0] dexp = 32'h0);
        bit          flt;
        bit          rmw;
        int          idx;
        int          sh;
        logic [31:0] w, v, m;
        exp_t        e;
        idx = int'(a >> 2);
        sh  = 8 * int'(a % 4);
        flt = (ld || st) && ((ld && st) || f3 == 3 || f3 == 6 || f3 == 7 ||
              (st && (f3 == 4 || f3 == 5)) || ((f3 == 1 || f3 == 5) && (a % 2) != 0) ||
              (f3 == 2 && (a % 4) != 0) || idx >= 64);
        rmw = 1'b0;
        if (flt) begin
            e.kind = 2; e.addr = 32'h0; e.data = 32'h0;
            sbq.push_back(e);
        end else if (ld) begin
            w = ref_mem[idx];
            case (f3)
                3'd0: begin v = (w >> sh) & 32'hFF; if (v[7]) v = v | 32'hFFFFFF00; end
                3'd1: begin v = (w >> sh) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
                3'd4: v = (w >> sh) & 32'hFF;
                3'd5: v = (w >> sh) & 32'hFFFF;
                default: v = w;
            endcase
            e.kind = 0; e.addr = 32'(idx); e.data = v;
            sbq.push_back(e);
        end else if (st) begin
            w = ref_mem[idx];
            if (f3 == 3'd2) begin
                v = wd;
            end else begin
                m   = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
                v   = (w & ~(m << sh)) | ((wd & m) << sh);
                rmw = 1'b1;
            end
            ref_mem[idx] = v;
            e.kind = 1; e.addr = 32'(idx); e.data = v;
            sbq.push_back(e);
        end
        LD_EN = ld; ST_EN = st; FUNCT3 = f3; ADDR = a; WDATA = wd;
        @(negedge CLK);
        chk("stall", {31'h0, STALL}, {31'h0, rmw});
        chk("fault_cnt", {24'h0, FAULT_CNT}, 32'(cnt_model));
        if (rmw) chk("rmw_read", {31'h0, MEMR}, 32'h1);
        if (!ld && !st) chk("idle_quiet", {29'h0, MEMR, MEMW, FAULT} | LOAD_DATA, 32'h0);
        if (dchk && !rmw) chk("directed", st ? MEM_DATA_W : LOAD_DATA, dexp);
        @(posedge CLK);
        if (flt && cnt_model < 255) cnt_model++;
        if (rmw) begin
            // Inputs are ignored during the write-back cycle; drive junk to prove it.
            #1;
            LD_EN = 1'($urandom); ST_EN = 1'($urandom); FUNCT3 = 3'($urandom);
            ADDR = $urandom; WDATA = $urandom;
            @(negedge CLK);
            chk("rmw_stall", {31'h0, STALL}, 32'h0);
            if (dchk) chk("directed_rmw", MEM_DATA_W, dexp);
            @(posedge CLK);
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        RST = 1'b1; LD_EN = 1'b1; ST_EN = 1'b0; FUNCT3 = 3'd2; ADDR = 32'h14; WDATA = 32'h0;
        repeat (2) @(negedge CLK);
        chk("rst_ctrl", {28'h0, MEMR, MEMW, STALL, FAULT}, 32'h0);
        chk("rst_load", LOAD_DATA, 32'h0);
        chk("rst_cnt", {24'h0, FAULT_CNT}, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0; LD_EN = 1'b0;

        op(0, 1, 3'd2, 32'h14, 32'h11223344, 1'b1, 32'h11223344);
        op(1, 0, 3'd2, 32'h14, 32'h0, 1'b1, 32'h11223344);
        op(0, 1, 3'd0, 32'h15, 32'h000000AB, 1'b1, 32'h1122AB44);
        op(1, 0, 3'd0, 32'h15, 32'h0, 1'b1, 32'hFFFFFFAB);
        op(1, 0, 3'd4, 32'h15, 32'h0, 1'b1, 32'h000000AB);
        op(0, 1, 3'd1, 32'h16, 32'h1234BEEF, 1'b1, 32'hBEEFAB44);
        op(1, 0, 3'd1, 32'h16, 32'h0, 1'b1, 32'hFFFFBEEF);
        op(1, 0, 3'd5, 32'h14, 32'h0, 1'b1, 32'h0000AB44);
        op(1, 0, 3'd2, 32'h13, 32'h0);
        op(0, 1, 3'd1, 32'h17, 32'h5555);
        op(1, 0, 3'd0, 32'h100, 32'h0);
        chk("fault_cnt3", {24'h0, FAULT_CNT}, 32'h3);
        op(1, 1, 3'd2, 32'h14, 32'hDEADBEEF);
        op(1, 0, 3'd2, 32'h14, 32'h0, 1'b1, 32'hBEEFAB44);
        op(0, 0, 3'd2, 32'h14, 32'h0);

        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 19));
            f3 = (r < 16) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            if (r % 4 == 3) f3 = 3'($urandom_range(4, 5));
            a  = (r == 19) ? $urandom : 32'($urandom_range(0, 271));
            if (r < 9)       op(1, 0, f3, a, $urandom);
            else if (r < 17) op(0, 1, f3, a, $urandom);
            else if (r == 17) op(1, 1, f3, a, $urandom);
            else             op(0, 0, f3, a, $urandom);
        end

        for (int n = 0; n < 300; n++) op(1, 0, 3'd3, 32'h0, 32'h0);
        chk("fault_sat", {24'h0, FAULT_CNT}, 32'hFF);

        // Reset while the write-back of an SB is pending must suppress the write.
        op(0, 1, 3'd2, 32'h08, 32'hCAFEF00D);
        LD_EN = 1'b0; ST_EN = 1'b1; FUNCT3 = 3'd0; ADDR = 32'h08; WDATA = 32'h55;
        @(negedge CLK);
        chk("rmw_rst_stall", {31'h0, STALL}, 32'h1);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("rmw_rst_nowrite", {30'h0, MEMW, STALL}, 32'h0);
        end
        sbq.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        cnt_model = 0;
        @(posedge CLK); #1;
        RST = 1'b0; ST_EN = 1'b0;
        op(1, 0, 3'd2, 32'h08, 32'h0, 1'b1, 32'h0);
        chk("cnt_after_rst", {24'h0, FAULT_CNT}, 32'h0);

        LD_EN = 1'b0; ST_EN = 1'b0;
        repeat (3) @(posedge CLK);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the ALU/control path and the 64-word data memory.
- Converts byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's MEMR/MEMW/MEM_ADDRESS/MEM_DATA_W/MEM_DATA_R port.
- The memory only writes full words, so SB/SH run a two-cycle read-modify-write (RMW) sequence and stall the core.
- Misaligned and out-of-range accesses are blocked, flagged and counted.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; word index must be < MEM_WORDS.
- CNT_W, 8, width of the saturating fault counter.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- LD_EN  in  1  load request this cycle
- ST_EN  in  1  store request this cycle
- FUNCT3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ADDR  in  32  byte address (ALU output)
- WDATA  in  32  store data (rs2)
- LOAD_DATA  out  32  extended load result
- STALL  out  1  core must hold PC and all request inputs
- FAULT  out  1  current request is misaligned, out of range or illegal
- FAULT_CNT  out  CNT_W  saturating count of faulted requests
- MEMR  out  1  to memory read enable
- MEMW  out  1  to memory write enable
- MEM_ADDRESS  out  32  word index, {2'b0, ADDR[31:2]}
- MEM_DATA_W  out  32  word to write
- MEM_DATA_R  in  32  memory read data, combinational, 0 when MEMR=0

Behaviour:
- State register: IDLE, RMW_WR. Reset state is IDLE. Internal registers reset to 0: merge register, latched word index, FAULT_CNT.
- While RST is high: MEMR=0, MEMW=0, STALL=0, LOAD_DATA=0, FAULT=0.
- Fault condition, evaluated in IDLE only:
  - (LD_EN & ST_EN), or
  - H/HU with ADDR[0]=1, or
  - W with ADDR[1:0]!=0, or
  - ADDR[31:2] >= MEM_WORDS, or
  - undefined FUNCT3 (011, 110, 111; BU/HU with ST_EN).
- On a fault: FAULT=1 combinationally, no MEMR/MEMW, LOAD_DATA=0, no stall. FAULT_CNT increments on that clock edge and saturates at all-ones.
- Load (IDLE, LD_EN, no fault): MEMR=1 and MEM_ADDRESS=word index in the same cycle. LOAD_DATA is combinational from MEM_DATA_R, zero latency, no stall.
  - Byte lane selected by ADDR[1:0]; halfword lane by ADDR[1].
  - B/H are sign-extended; BU/HU are zero-extended.
- SW (IDLE, no fault): MEMW=1, MEM_DATA_W=WDATA the same cycle; write lands at the clock edge; no stall.
- SB/SH, cycle 1 (IDLE):
  - Outputs MEMR=1, STALL=1.
  - At the clock edge, the merge register captures MEM_DATA_R with the addressed lane replaced by WDATA[7:0] (SB) or WDATA[15:0] (SH).
  - Word index is latched; state moves to RMW_WR.
- SB/SH, cycle 2 (RMW_WR):
  - Outputs MEMW=1, MEM_DATA_W=merge register, MEM_ADDRESS=latched index, MEMR=0, STALL=0.
  - Returns to IDLE. Inputs are ignored in this state; the core presents the next instruction on the following cycle.
- Latency: loads and SW take 1 cycle; SB/SH take exactly 2 cycles.
- Reset in RMW_WR: state returns to IDLE immediately and no write is issued. Memory contents are also cleared by the shared RST.
- LD_EN=ST_EN=0: all memory controls 0, LOAD_DATA=0, FAULT=0.

Test Plan:
- After reset: SW 0x11223344 to ADDR 0x14 → MEMW=1, MEM_ADDRESS=5, no stall. Then LW 0x14 → LOAD_DATA=0x11223344.
- SB WDATA=0x000000AB to 0x15 → cycle 1: STALL=1, MEMR=1. Cycle 2: MEMW=1, MEM_DATA_W=0x1122AB44. Then LB 0x15 → 0xFFFFFFAB; LBU 0x15 → 0x000000AB.
- SH WDATA=0x1234BEEF to 0x16 → word 5 becomes 0xBEEFAB44. Then LH 0x16 → 0xFFFFBEEF; LHU 0x14 → 0x0000AB44.
- LW 0x13, SH 0x17, and LB 0x100 (index 64) → each sets FAULT=1 with no MEMR/MEMW; FAULT_CNT goes 0→3. Force 300 faults with CNT_W=8 → FAULT_CNT holds at 0xFF.
- SB to 0x08 with RST asserted during RMW_WR → MEMW never 1, state IDLE, STALL=0, word 2 reads 0 after reset.
- LD_EN=ST_EN=1 on an aligned word → FAULT=1, no access, memory unchanged.
